// File: rtl/store_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : store_buffer                                                 |
// | Description : Circular store queue between the core and data memory.       |
// |               Stores are aligned to a memory word, their byte enables and  |
// |               replicated lane data are computed, and the result is queued. |
// |               The head entry is presented to memory from registers.        |
// |               Misaligned stores are dropped and flagged on st_err. A       |
// |               combinational load-hazard check reports pending stores to    |
// |               the same word as ld_addr.                                    |
// | Options     : define STORE_BUF_MERGE_EN to merge a store into the youngest |
// |               entry when both target the same word.                        |
// | Ports       : clk, reset          clock, async active-high reset           |
// |               in_valid/in_ready   store request handshake                  |
// |               in_addr/in_memop/in_wdata  store request payload             |
// |               m_data_*            head entry towards memory                |
// |               ld_addr/ld_hit      load hazard query                        |
// |               st_err              one-cycle misaligned-store pulse         |
// |               count               occupied entries                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module store_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDR_W-1:0]       in_addr,
    input  logic [2:0]              in_memop,
    input  logic [DATA_W-1:0]       in_wdata,
    output logic                    m_data_valid,
    input  logic                    m_data_ready,
    output logic [ADDR_W-1:0]       m_data_addr,
    output logic [DATA_W-1:0]       m_data_wdata,
    output logic [DATA_W/8-1:0]     m_data_byteen,
    input  logic [ADDR_W-1:0]       ld_addr,
    output logic                    ld_hit,
    output logic                    st_err,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int c_lanes = DATA_W / 8;
    localparam int c_offw  = $clog2(c_lanes);
    localparam int c_ptrw  = $clog2(DEPTH);
    localparam int c_cntw  = c_ptrw + 1;

    localparam logic [2:0] c_op_none = 3'd0;
    localparam logic [2:0] c_op_sw   = 3'd1;
    localparam logic [2:0] c_op_sh   = 3'd2;
    localparam logic [2:0] c_op_sb   = 3'd3;
    localparam logic [2:0] c_op_sd   = 3'd4;

    // Queue storage; an entry is live exactly when its byte enables are non-zero
    logic [ADDR_W-1:0]  r_addr [DEPTH];
    logic [DATA_W-1:0]  r_data [DEPTH];
    logic [c_lanes-1:0] r_be   [DEPTH];
    logic [c_ptrw-1:0]  r_wptr;
    logic [c_ptrw-1:0]  r_rptr;
    logic [c_cntw-1:0]  r_count;
    logic               r_st_err;

    logic [c_offw-1:0]  w_off;
    logic [c_lanes-1:0] w_byteen;
    logic [DATA_W-1:0]  w_wdata;
    logic [DATA_W-1:0]  w_mask;
    logic               w_misal;
    logic               w_legal;
    logic [ADDR_W-1:0]  w_waddr;
    logic [ADDR_W-1:0]  w_ld_word;
    logic [c_ptrw-1:0]  w_young;
    logic               w_merge_hit;
    logic               w_accept;
    logic               w_push;
    logic               w_merge;
    logic               w_pop;
    logic [DEPTH-1:0]   w_hit_vec;
    logic               w_unused_ld_low;

    assign w_off     = in_addr[c_offw-1:0];
    assign w_waddr   = {in_addr[ADDR_W-1:c_offw], {c_offw{1'b0}}};
    assign w_ld_word = {ld_addr[ADDR_W-1:c_offw], {c_offw{1'b0}}};
    // Only the word part of the load address matters for the hazard check
    assign w_unused_ld_low = &{1'b0, ld_addr[c_offw-1:0]};

    // Byte enables, lane replication and alignment check for the incoming op
    always_comb begin
        w_byteen = '0;
        w_wdata  = in_wdata;
        w_misal  = 1'b0;
        case (in_memop)
            c_op_none: ;
            c_op_sw: begin
                w_byteen = c_lanes'(4'hF) << w_off;
                w_wdata  = {(c_lanes/4){in_wdata[31:0]}};
                w_misal  = (w_off[1:0] != 2'b00);
            end
            c_op_sh: begin
                w_byteen = c_lanes'(2'b11) << w_off;
                w_wdata  = {(c_lanes/2){in_wdata[15:0]}};
                w_misal  = w_off[0];
            end
            c_op_sb: begin
                w_byteen = c_lanes'(1'b1) << w_off;
                w_wdata  = {c_lanes{in_wdata[7:0]}};
            end
            c_op_sd: begin
                w_byteen = '1;
                // A doubleword cannot be stored through a 32-bit port
                w_misal  = (DATA_W == 32) || (w_off != '0);
            end
            default: w_misal = 1'b1;
        endcase
    end

    assign w_legal = (in_memop != c_op_none) && !w_misal;

    // Byte enables widened to a bit mask for partial lane overwrite on merge
    generate
        for (genvar g = 0; g < c_lanes; g++) begin : g_mask
            assign w_mask[8*g +: 8] = {8{w_byteen[g]}};
        end
    endgenerate

    assign m_data_valid = (r_count != '0);
    assign w_pop        = m_data_valid && m_data_ready;
    assign w_young      = r_wptr - c_ptrw'(1);

`ifdef STORE_BUF_MERGE_EN
    // With a single entry the youngest is also the head; it cannot be merged
    // into while it is leaving the queue
    assign w_merge_hit = w_legal && (r_count != '0) && (r_addr[w_young] == w_waddr)
                         && !(w_pop && (r_count == c_cntw'(1)));
`else
    assign w_merge_hit = 1'b0;
`endif

    // A pop this cycle deliberately does not make room for a push
    assign in_ready = (r_count < c_cntw'(DEPTH)) || w_merge_hit;
    assign w_accept = in_valid && in_ready;
    assign w_push   = w_accept && w_legal && !w_merge_hit;
    assign w_merge  = w_accept && w_legal && w_merge_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_st_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
                r_be[i]   <= '0;
            end
        end else begin
            r_st_err <= w_accept && w_misal;
            if (w_pop) begin
                r_be[r_rptr] <= '0;
                r_rptr       <= r_rptr + c_ptrw'(1);
            end
            // A push slot never coincides with the head being popped: pushes
            // into the head slot only happen when the queue is empty
            if (w_push) begin
                r_addr[r_wptr] <= w_waddr;
                r_data[r_wptr] <= w_wdata;
                r_be[r_wptr]   <= w_byteen;
                r_wptr         <= r_wptr + c_ptrw'(1);
            end else if (w_merge) begin
                r_data[w_young] <= (r_data[w_young] & ~w_mask) | (w_wdata & w_mask);
                r_be[w_young]   <= r_be[w_young] | w_byteen;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cntw'(1);
                2'b01:   r_count <= r_count - c_cntw'(1);
                default: ;
            endcase
        end
    end

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_ld_cmp
            assign w_hit_vec[g] = (r_be[g] != '0) && (r_addr[g] == w_ld_word);
        end
    endgenerate

    assign ld_hit        = |w_hit_vec;
    assign m_data_addr   = m_data_valid ? r_addr[r_rptr] : '0;
    assign m_data_wdata  = m_data_valid ? r_data[r_rptr] : '0;
    assign m_data_byteen = m_data_valid ? r_be[r_rptr]   : '0;
    assign st_err        = r_st_err;
    assign count         = r_count;

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_store_buffer                                              |
// | Description : Scoreboard bench for store_buffer. A driver issues directed  |
// |               and random stores, keeps a queue-level reference of pending  |
// |               entries, and a monitor pops the reference whenever the DUT   |
// |               hands an entry to memory.                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_store_buffer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int LANES  = DATA_W / 8;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [ADDR_W-1:0]       in_addr = '0;
    logic [2:0]              in_memop = '0;
    logic [DATA_W-1:0]       in_wdata = '0;
    logic                    m_data_valid;
    logic                    m_data_ready = 1'b0;
    logic [ADDR_W-1:0]       m_data_addr;
    logic [DATA_W-1:0]       m_data_wdata;
    logic [LANES-1:0]        m_data_byteen;
    logic [ADDR_W-1:0]       ld_addr = '0;
    logic                    ld_hit;
    logic                    st_err;
    logic [$clog2(DEPTH):0]  count;

    store_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_addr      (in_addr),
        .in_memop     (in_memop),
        .in_wdata     (in_wdata),
        .m_data_valid (m_data_valid),
        .m_data_ready (m_data_ready),
        .m_data_addr  (m_data_addr),
        .m_data_wdata (m_data_wdata),
        .m_data_byteen(m_data_byteen),
        .ld_addr      (ld_addr),
        .ld_hit       (ld_hit),
        .st_err       (st_err),
        .count        (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [LANES-1:0]  be;
    } entry_t;

    entry_t exp_q[$];
    int     checks = 0;
    int     errors = 0;
    bit     err_pending = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference decode: each lane k takes byte (k mod size) of the store data,
    // and lanes off..off+size-1 are enabled
    function automatic void decode(input logic [ADDR_W-1:0] a, input logic [2:0] op,
                                   input logic [DATA_W-1:0] wd,
                                   output bit legal, output bit mis, output entry_t e);
        int off;
        int size;
        off = int'(a % LANES);
        case (op)
            3'd1:    size = 4;
            3'd2:    size = 2;
            3'd3:    size = 1;
            3'd4:    size = 8;
            default: size = 0;
        endcase
        mis   = (op >= 3'd5) || (op == 3'd4 && DATA_W == 32) || (size != 0 && (off % size) != 0);
        legal = (op != 3'd0) && !mis;
        e.addr = a - ADDR_W'(off);
        e.be   = '0;
        e.data = '0;
        for (int k = 0; k < LANES; k++) begin
            if (size != 0 && k >= off && k < off + size) e.be[k] = 1'b1;
            e.data[8*k +: 8] = wd[8*(k % (size == 0 ? 1 : size)) +: 8];
        end
    endfunction

    // One clock of stimulus with checks of all combinational/registered outputs
    task automatic cycle(input logic v, input logic [ADDR_W-1:0] a, input logic [2:0] op,
                         input logic [DATA_W-1:0] wd, input logic rdy, input logic [ADDR_W-1:0] la);
        bit     legal, mis, merge, pop, hit, acc;
        entry_t e, t;
        int     n;
        int     idx;
        @(negedge clk);
        in_valid = v; in_addr = a; in_memop = op; in_wdata = wd;
        m_data_ready = rdy; ld_addr = la;
        #1;
        decode(a, op, wd, legal, mis, e);
        n     = exp_q.size();
        pop   = (n != 0) && rdy;
        merge = 0;
`ifdef STORE_BUF_MERGE_EN
        if (legal && n != 0) merge = (exp_q[n-1].addr == e.addr) && !(pop && n == 1);
`endif
        hit = 0;
        foreach (exp_q[i]) if (exp_q[i].addr == la - (la % LANES)) hit = 1;
        chk("count", 64'(count), 64'(n));
        chk("in_ready", 64'(in_ready), 64'((n < DEPTH) || merge));
        chk("m_data_valid", 64'(m_data_valid), 64'(n != 0));
        chk("ld_hit", 64'(ld_hit), 64'(hit));
        chk("st_err", 64'(st_err), 64'(err_pending));
        if (n == 0) begin
            chk("empty_byteen", 64'(m_data_byteen), 64'd0);
            chk("empty_wdata", 64'(m_data_wdata), 64'd0);
        end
        acc = v && ((n < DEPTH) || merge);
        @(posedge clk);
        err_pending = acc && mis;
        if (acc && legal) begin
            if (merge) begin
                idx = exp_q.size() - 1;
                t = exp_q[idx];
                for (int k = 0; k < LANES; k++)
                    if (e.be[k]) begin
                        t.be[k] = 1'b1;
                        t.data[8*k +: 8] = e.data[8*k +: 8];
                    end
                exp_q[idx] = t;
            end else begin
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 3'd0, '0, 1'b1, '0);
    endtask

    task automatic reset_mid();
        @(negedge clk);
        in_valid = 1'b0;
        m_data_ready = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        exp_q.delete();
        err_pending = 0;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(m_data_valid), 64'd0);
        chk("rst_byteen", 64'(m_data_byteen), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: every accepted head must match the oldest expected entry
    initial begin
        entry_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && m_data_valid && m_data_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_empty: DUT presented addr %0h, scoreboard expected no entry", m_data_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("head_addr", 64'(m_data_addr), 64'(e.addr));
                    chk("head_wdata", 64'(m_data_wdata), 64'(e.data));
                    chk("head_byteen", 64'(m_data_byteen), 64'(e.be));
                end
            end
        end
    end

    initial begin
        #2;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_valid", 64'(m_data_valid), 64'd0);
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_st_err", 64'(st_err), 64'd0);
        #10;
        reset = 1'b0;

        // Byte store replicated to all lanes, enable on lane 3
        cycle(1'b1, 32'h1003, 3'd3, 32'h0000_00AB, 1'b1, '0);
        #2;
        chk("sb_addr", 64'(m_data_addr), 64'h1000);
        chk("sb_byteen", 64'(m_data_byteen), 64'b1000);
        chk("sb_wdata", 64'(m_data_wdata), 64'hABAB_ABAB);
        drain(2);

        // Misaligned halfword: dropped, single st_err pulse
        cycle(1'b1, 32'h2001, 3'd2, 32'h1234, 1'b1, '0);
        #2;
        chk("mis_st_err", 64'(st_err), 64'd1);
        chk("mis_count", 64'(count), 64'd0);
        drain(2);

        // Fill to full with distinct words, then drain in order
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 32'h500 + 32'(4*i), 3'd1, $urandom, 1'b0, '0);
        drain(6);

        // Load hazard on same word / next word
        cycle(1'b1, 32'h4000, 3'd1, 32'hDEAD_BEEF, 1'b0, '0);
        #1;
        ld_addr = 32'h4002;
        #1;
        chk("ld_hit_same_word", 64'(ld_hit), 64'd1);
        ld_addr = 32'h4004;
        #1;
        chk("ld_hit_next_word", 64'(ld_hit), 64'd0);
        drain(3);

`ifdef STORE_BUF_MERGE_EN
        cycle(1'b1, 32'h3000, 3'd3, 32'h11, 1'b0, '0);
        cycle(1'b1, 32'h3002, 3'd3, 32'h22, 1'b0, '0);
        #2;
        chk("merge_count", 64'(count), 64'd1);
        chk("merge_byteen", 64'(m_data_byteen), 64'b0101);
        chk("merge_lane0", 64'(m_data_wdata[7:0]), 64'h11);
        chk("merge_lane2", 64'(m_data_wdata[23:16]), 64'h22);
        drain(3);
`endif

        // Reset with three entries queued
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'h600 + 32'(4*i), 3'd1, $urandom, 1'b0, '0);
        reset_mid();
        drain(2);

        // Random traffic over a small address window to exercise hazards
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 1)),
                  32'h100 + 32'($urandom_range(0, 23)),
                  3'($urandom_range(0, 7)),
                  $urandom,
                  1'($urandom_range(0, 9) < 6),
                  32'h100 + 32'($urandom_range(0, 23)));
        end
        drain(DEPTH + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
